// File: rtl/residue_mac_if.sv
// Valid/ready operand stream and frame-result stream for residue_mac.
// master drives operands and out_ready; slave is the MAC stage.
interface residue_mac_if #(
    parameter int unsigned P = 64
);
    localparam int unsigned DELTA = $clog2(P);

    logic             in_valid;
    logic             in_ready;
    logic [DELTA-1:0] in_a;
    logic [DELTA-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [DELTA-1:0] out_vec;
    logic             err;

    modport master (
        output in_valid,
        input  in_ready,
        output in_a,
        output in_b,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_vec,
        input  err
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_a,
        input  in_b,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_vec,
        output err
    );
endinterface

// File: rtl/residue_mac.sv
// Sequential mod-P multiply-accumulate over framed residue pairs (MSB-first shift-add multiply).
// Optional operand range check and sticky err enabled by RESIDUE_MAC_RANGE_CHECK_EN.
module residue_mac #(
    parameter int unsigned P = 64
) (
    input logic           clk,
    input logic           rst_n,
    residue_mac_if.slave  bus
);
    localparam int unsigned DELTA = $clog2(P);
    localparam int unsigned CW    = (DELTA > 1) ? $clog2(DELTA) : 1;
    localparam logic [DELTA:0] PW = (DELTA + 1)'(P);

    typedef enum logic [1:0] {StIdle, StMul, StAcc, StDone} state_e;

    state_e           state_q, state_d;
    logic [DELTA-1:0] a_q, a_d;
    logic [DELTA-1:0] b_q, b_d;
    logic             last_q, last_d;
    logic [DELTA-1:0] prod_q, prod_d;
    logic [DELTA-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DELTA-1:0] a_in, b_in;
    logic [DELTA:0]   mul_dbl, mul_sum, acc_sum;
    logic [DELTA-1:0] prod_next, acc_next;

`ifdef RESIDUE_MAC_RANGE_CHECK_EN
    logic err_q, err_d;
    logic a_bad, b_bad;

    // A DELTA-bit value is below 2P, so one conditional subtract reduces it exactly.
    always_comb begin
        a_bad = ({1'b0, bus.in_a} >= PW);
        b_bad = ({1'b0, bus.in_b} >= PW);
        a_in  = a_bad ? DELTA'({1'b0, bus.in_a} - PW) : bus.in_a;
        b_in  = b_bad ? DELTA'({1'b0, bus.in_b} - PW) : bus.in_b;
    end
`else
    always_comb begin
        a_in = bus.in_a;
        b_in = bus.in_b;
    end
`endif

    // One multiplier step: double, reduce, conditionally add a, reduce.
    always_comb begin
        mul_dbl = {prod_q, 1'b0};
        if (mul_dbl >= PW) begin
            mul_dbl = mul_dbl - PW;
        end
        mul_sum = mul_dbl;
        if (b_q[cnt_q]) begin
            mul_sum = mul_dbl + {1'b0, a_q};
            if (mul_sum >= PW) begin
                mul_sum = mul_sum - PW;
            end
        end
        prod_next = mul_sum[DELTA-1:0];
    end

    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, prod_q};
        if (acc_sum >= PW) begin
            acc_sum = acc_sum - PW;
        end
        acc_next = acc_sum[DELTA-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef RESIDUE_MAC_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StMul;
                    a_d     = a_in;
                    b_d     = b_in;
                    last_d  = bus.in_last;
                    prod_d  = '0;
                    cnt_d   = CW'(DELTA - 1);
`ifdef RESIDUE_MAC_RANGE_CHECK_EN
                    if (a_bad || b_bad) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            StMul: begin
                prod_d = prod_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                acc_d   = acc_next;
                state_d = last_q ? StDone : StIdle;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    acc_d   = '0;
`ifdef RESIDUE_MAC_RANGE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RESIDUE_MAC_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Handshake outputs come straight from state, so no combinational input-to-output path.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_vec   = (state_q == StDone) ? acc_q : '0;

endmodule

// File: tb/tb_residue_mac.sv
// Self-checking bench for residue_mac at P = 61: vector table plus scoreboard of frame results,
// with hand-written back-pressure and mid-MUL reset sequences.
module tb_residue_mac;
    localparam int unsigned P     = 61;
    localparam int          DELTA = 6;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        bit         last;
        int         exp_vec;
        bit         exp_err;
        bit         chk_vec;
        int         hold;
    } vec_t;

    typedef struct {
        int vec;
        bit err;
        bit chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    residue_mac_if #(.P(P)) bus ();

    residue_mac #(.P(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits for in_ready, drives one pair; acc_edge is the edge count just after acceptance.
    task automatic send_pair(input logic [5:0] a, input logic [5:0] b, input bit last,
                             input bit push, input int exp_vec, input bit exp_err,
                             input bit chk, output int acc_edge);
        int   n = 0;
        exp_t e;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready timeout", 0, 1);
            acc_edge = cyc;
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        if (push && last) begin
            e.vec = exp_vec;
            e.err = exp_err;
            e.chk = chk;
            sb.push_back(e);
        end
        @(negedge clk);
        acc_edge     = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Waits for the frame result, compares against the scoreboard, optionally stalls, handshakes.
    task automatic collect(input int acc_edge, input int hold);
        int   n = 0;
        bit   rdy_seen = 1'b0;
        exp_t e;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            check("out_valid timeout", 0, 1);
            return;
        end
        // Accept at edge 0, seven more edges (6 MUL + 1 ACC) reach DONE.
        check("out_valid latency", cyc - acc_edge, DELTA + 1);
        check("in_ready low during frame", int'(rdy_seen), 0);
        if (sb.size() == 0) begin
            check("scoreboard underflow", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (e.chk) check("out_vec", int'(bus.out_vec), e.vec);
        check("err in DONE", int'(bus.err), int'(e.err));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 6'd3;
            bus.in_b     = 6'd3;
            bus.in_last  = 1'b1;
            @(negedge clk);
            check("out_valid held", int'(bus.out_valid), 1);
            if (e.chk) check("out_vec held", int'(bus.out_vec), e.vec);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid after handshake", int'(bus.out_valid), 0);
        check("in_ready after handshake", int'(bus.in_ready), 1);
        check("err after handshake", int'(bus.err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int edge_n;
        int prev_edge;

        vecs[0] = '{a: 6'd7,  b: 6'd9,  last: 1'b1, exp_vec: 2,  exp_err: 1'b0, chk_vec: 1'b1, hold: 0};
        vecs[1] = '{a: 6'd60, b: 6'd60, last: 1'b0, exp_vec: 0,  exp_err: 1'b0, chk_vec: 1'b0, hold: 0};
        vecs[2] = '{a: 6'd5,  b: 6'd3,  last: 1'b1, exp_vec: 16, exp_err: 1'b0, chk_vec: 1'b1, hold: 5};
        vecs[3] = '{a: 6'd1,  b: 6'd1,  last: 1'b1, exp_vec: 1,  exp_err: 1'b0, chk_vec: 1'b1, hold: 0};
        vecs[4] = '{a: 6'd0,  b: 6'd45, last: 1'b1, exp_vec: 0,  exp_err: 1'b0, chk_vec: 1'b1, hold: 0};
`ifdef RESIDUE_MAC_RANGE_CHECK_EN
        vecs[5] = '{a: 6'd60, b: 6'd63, last: 1'b1, exp_vec: 59, exp_err: 1'b1, chk_vec: 1'b1, hold: 0};
        vecs[6] = '{a: 6'd63, b: 6'd10, last: 1'b1, exp_vec: 20, exp_err: 1'b1, chk_vec: 1'b1, hold: 0};
`else
        vecs[5] = '{a: 6'd60, b: 6'd63, last: 1'b1, exp_vec: 0,  exp_err: 1'b0, chk_vec: 1'b0, hold: 0};
        vecs[6] = '{a: 6'd63, b: 6'd10, last: 1'b1, exp_vec: 0,  exp_err: 1'b0, chk_vec: 1'b0, hold: 0};
`endif

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", int'(bus.in_ready), 1);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_vec", int'(bus.out_vec), 0);
        check("reset err", int'(bus.err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        prev_edge = 0;
        for (int i = 0; i < 7; i++) begin
            send_pair(vecs[i].a, vecs[i].b, vecs[i].last, 1'b1, vecs[i].exp_vec,
                      vecs[i].exp_err, vecs[i].chk_vec, edge_n);
            if (i == 2) check("second accept gap", edge_n - prev_edge, DELTA + 2);
            prev_edge = edge_n;
            if (vecs[i].last) collect(edge_n, vecs[i].hold);
        end

        // Reset after three MUL cycles: frame is dropped, outputs return to idle values.
        send_pair(6'd4, 6'd5, 1'b1, 1'b0, 0, 1'b0, 1'b0, edge_n);
        repeat (2) @(negedge clk);
        check("in_ready before reset", int'(bus.in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("mid-MUL reset in_ready", int'(bus.in_ready), 1);
        check("mid-MUL reset out_valid", int'(bus.out_valid), 0);
        check("mid-MUL reset out_vec", int'(bus.out_vec), 0);
        check("mid-MUL reset err", int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no output after reset", int'(bus.out_valid), 0);
        send_pair(6'd2, 6'd3, 1'b1, 1'b1, 6, 1'b0, 1'b1, edge_n);
        collect(edge_n, 0);
        check("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
